// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction fetch stage.
package fetch_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_DEPTH  = 2;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {addr, data} words; flush overrides push and pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  fetch_entry_t     push_entry,
   input  logic             pop,
   output logic [CNT_W-1:0] count,
   output logic             head_valid,
   output fetch_entry_t     head
);

   localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push_s, do_pop_s;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // Pointer, count and storage update
   always_comb begin
      do_pop_s  = pop && (count_q != '0);
      // a push into a full FIFO is fine when the head leaves in the same cycle
      do_push_s = push && ((count_q != FULL_CNT) || do_pop_s);
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push_s) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = next_ptr(wr_ptr_q);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control registers
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head is masked while empty
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   assign count      = count_q;
   assign head_valid = (count_q != '0);
   assign head       = head_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC, requests words from instruction
// memory, buffers them and hands them to decode; jumps discard stale fetches.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc,
   output logic              pc_inc,
   output logic              pc_load,
   output logic [ADDR_W-1:0] pc_in,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_data,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready
);

   localparam int             CNT_W     = $clog2(DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(DEPTH);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic [CNT_W-1:0]  count_s;
   logic [CNT_W:0]    occ_after_s;
   logic              head_valid_s;
   logic              push_s, pop_s;
   fetch_entry_t      push_entry_s, head_s;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .flush      (jump),
      .push       (push_s),
      .push_entry (push_entry_s),
      .pop        (pop_s),
      .count      (count_s),
      .head_valid (head_valid_s),
      .head       (head_s)
   );

   // State and request-address register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= FETCH;
         req_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         req_addr_q <= req_addr_d;
      end
   end

   // Next-state and next request address
   always_comb begin
      state_d     = state_q;
      req_addr_d  = req_addr_q;
      occ_after_s = {1'b0, count_s} + (CNT_W + 1)'(1) - {{CNT_W{1'b0}}, pop_s};
      case (state_q)
         FETCH: begin
            if (!jump && ({1'b0, count_s} < DEPTH_EXT)) begin
               state_d    = WAIT;
               req_addr_d = pc;
            end else begin
               state_d = FETCH;
            end
         end
         WAIT: begin
            if (jump) begin
               state_d = imem_ack ? FETCH : DRAIN;
            end else if (imem_ack) begin
               // issue the following word straight away only if it will fit
               if (occ_after_s < DEPTH_EXT) begin
                  state_d    = WAIT;
                  req_addr_d = req_addr_q + ADDR_W'(1);
               end else begin
                  state_d = FETCH;
               end
            end else begin
               state_d = WAIT;
            end
         end
         DRAIN: begin
            state_d = imem_ack ? FETCH : DRAIN;
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   // Memory, PC and FIFO control decode
   always_comb begin
      imem_req            = (state_q != FETCH);
      imem_addr           = imem_req ? req_addr_q : '0;
      push_s              = (state_q == WAIT) && imem_ack && !jump;
      push_entry_s.addr   = req_addr_q;
      push_entry_s.data   = imem_data;
      pop_s               = head_valid_s && instr_ready;
      pc_inc              = push_s;
      pc_load             = jump;
      pc_in               = jump ? jump_target : '0;
   end

   assign instr_valid = head_valid_s;
   assign instr       = head_s.data;
   assign instr_pc    = head_s.addr;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, then randomized traffic against a
// stream-level model (expected fetch order, PC tracking, stale-fetch rules).
module tb_fetch_unit;

   localparam int          AW  = 16;
   localparam int          DW  = 16;
   localparam int          DEP = 2;
   localparam logic [15:0] KEY = 16'hA5A5;

   logic          clock = 1'b0;
   logic          reset;
   logic [AW-1:0] pc;
   logic          pc_inc, pc_load;
   logic [AW-1:0] pc_in;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [DW-1:0] imem_data;
   logic          jump;
   logic [AW-1:0] jump_target;
   logic          instr_valid;
   logic [DW-1:0] instr;
   logic [AW-1:0] instr_pc;
   logic          instr_ready;

   always #5 clock = ~clock;

   fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
      .clock       (clock),
      .reset       (reset),
      .pc          (pc),
      .pc_inc      (pc_inc),
      .pc_load     (pc_load),
      .pc_in       (pc_in),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_data   (imem_data),
      .jump        (jump),
      .jump_target (jump_target),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready)
   );

   typedef struct {
      logic        rst, ack, jmp;
      logic [15:0] tgt;
      logic        rdy;
      logic        req;
      logic [15:0] addr;
      logic        inc, load, vld;
      logic [15:0] ipc;
   } vec_t;

   vec_t vecs [22];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   logic          s_inc, s_load, s_req, s_rst;
   logic [AW-1:0] s_pcin, s_addr;

   // PC register sitting upstream of the fetch unit
   task automatic pc_update();
      if (s_rst) pc = '0;
      else if (s_load) pc = s_pcin;
      else if (s_inc) pc = pc + 16'd1;
   endtask

   task automatic sample();
      s_inc  = pc_inc;
      s_load = pc_load;
      s_pcin = pc_in;
      s_req  = imem_req;
      s_addr = imem_addr;
      s_rst  = reset;
   endtask

   initial begin
      logic          prev_rst;
      logic          busy, stale, pend, jump_prev, exp_inc;
      logic [AW-1:0] pend_addr, exp_next;
      int            lat, max_lat, delivered;

      // rst ack jmp tgt rdy | req addr inc load vld ipc
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0000};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0000};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b1, 1'b1, 16'h0002};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0000};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0000};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
      vecs[13] = '{1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b1, 1'b0, 16'h0000};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
      vecs[15] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0, 16'h0000};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'hFFFE};
      vecs[17] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hFFFF};
      vecs[18] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000};
      vecs[19] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000};
      vecs[20] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
      vecs[21] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};

      reset = 1'b1; pc = '0; imem_ack = 1'b0; imem_data = '0;
      jump = 1'b0; jump_target = '0; instr_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;

      // Directed cycle table
      prev_rst = 1'b1;
      for (int i = 0; i < 22; i++) begin
         reset       = vecs[i].rst;
         imem_ack    = vecs[i].ack;
         jump        = vecs[i].jmp;
         jump_target = vecs[i].tgt;
         instr_ready = vecs[i].rdy;
         imem_data   = imem_addr ^ KEY;
         @(negedge clock);
         check($sformatf("v%0d imem_req", i), 32'(imem_req), 32'(vecs[i].req));
         check($sformatf("v%0d imem_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
         check($sformatf("v%0d pc_inc", i), 32'(pc_inc), 32'(vecs[i].inc));
         check($sformatf("v%0d pc_load", i), 32'(pc_load), 32'(vecs[i].load));
         check($sformatf("v%0d pc_in", i), 32'(pc_in), vecs[i].jmp ? 32'(vecs[i].tgt) : 32'd0);
         check($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].vld));
         if (vecs[i].vld) begin
            check($sformatf("v%0d instr_pc", i), 32'(instr_pc), 32'(vecs[i].ipc));
            check($sformatf("v%0d instr", i), 32'(instr), 32'(vecs[i].ipc ^ KEY));
         end else if (prev_rst) begin
            check($sformatf("v%0d instr_pc_rst", i), 32'(instr_pc), 32'd0);
            check($sformatf("v%0d instr_rst", i), 32'(instr), 32'd0);
         end
         sample();
         prev_rst = vecs[i].rst;
         @(posedge clock);
         #1;
         pc_update();
      end

      // Randomized traffic against the stream model
      reset = 1'b1; imem_ack = 1'b0; jump = 1'b0; instr_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      pc = '0; reset = 1'b0;
      busy = 1'b0; stale = 1'b0; pend = 1'b0; jump_prev = 1'b0;
      pend_addr = '0; exp_next = '0; lat = 0; delivered = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         max_lat     = (cyc < 1000) ? 0 : 3;
         jump        = ($urandom_range(0, 19) == 0);
         jump_target = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                                   : 16'($urandom);
         instr_ready = jump ? 1'b0 : ($urandom_range(0, 3) != 0);
         if (imem_req) begin
            if (!busy) begin
               busy = 1'b1;
               lat  = $urandom_range(0, max_lat);
            end
            imem_ack = (lat == 0);
            if (lat != 0) lat--;
         end else begin
            imem_ack = 1'b0;
         end
         imem_data = imem_addr ^ KEY;
         @(negedge clock);
         if (pend) begin
            check("hold_req", 32'(imem_req), 32'd1);
            check("hold_addr", 32'(imem_addr), 32'(pend_addr));
         end
         check("rnd pc_load", 32'(pc_load), 32'(jump));
         check("rnd pc_in", 32'(pc_in), jump ? 32'(jump_target) : 32'd0);
         exp_inc = imem_ack && !jump && !stale;
         check("rnd pc_inc", 32'(pc_inc), 32'(exp_inc));
         if (exp_inc) check("rnd ack_addr", 32'(imem_addr), 32'(pc));
         if (jump_prev) check("rnd post_jump_valid", 32'(instr_valid), 32'd0);
         if (instr_valid && instr_ready) begin
            check("rnd instr_pc", 32'(instr_pc), 32'(exp_next));
            check("rnd instr", 32'(instr), 32'(exp_next ^ KEY));
            exp_next = exp_next + 16'd1;
            delivered++;
         end
         sample();
         @(posedge clock);
         #1;
         pc_update();
         pend      = s_req && !imem_ack;
         pend_addr = s_addr;
         if (jump && s_req && !imem_ack) stale = 1'b1;
         else if (imem_ack) stale = 1'b0;
         if (imem_ack) busy = 1'b0;
         if (jump) exp_next = jump_target;
         jump_prev = jump;
      end
      check("liveness", 32'(delivered > 500), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly downstream of the 16-bit program counter. It reads the current PC value, issues word reads to instruction memory over a req/ack handshake, buffers fetched words with their addresses in a small prefetch FIFO, and presents them to decode over a valid/ready handshake. It is the only driver of the PC's `inc`, `load` and `in` controls; it redirects the PC on jumps from execute and discards stale fetches.

## Interface
- `ADDR_W`, 16, PC / instruction address width
- `DATA_W`, 16, instruction word width
- `DEPTH`, 2, prefetch FIFO entries (≥1)

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `pc`  in  ADDR_W  current PC value
- `pc_inc`  out  1  to PC `inc`
- `pc_load`  out  1  to PC `load`
- `pc_in`  out  ADDR_W  to PC `in` (load value)
- `imem_req`  out  1  memory read request
- `imem_addr`  out  ADDR_W  read address
- `imem_ack`  in  1  read complete; `imem_data` valid this cycle
- `imem_data`  in  DATA_W  read data
- `jump`  in  1  one-cycle redirect pulse from execute
- `jump_target`  in  ADDR_W  redirect address
- `instr_valid`  out  1  FIFO head valid
- `instr`  out  DATA_W  FIFO head instruction
- `instr_pc`  out  ADDR_W  address of FIFO head
- `instr_ready`  in  1  decode accepts head

## Operation
- States: FETCH (no request outstanding), WAIT (request outstanding, result wanted), DRAIN (request outstanding, result discarded).
- FETCH: if `count < DEPTH` and no `jump`, capture `req_addr <= pc`, go WAIT; else stay.
- WAIT: `imem_req=1`, `imem_addr=req_addr`. On `imem_ack` without `jump`: push {req_addr, imem_data}, `pc_inc=1` that cycle. If `count + 1 - pop < DEPTH`, stay WAIT with `req_addr <= req_addr + 1` (back-to-back); else go FETCH.
- `jump` (any state): `pc_load=1`, `pc_in=jump_target`, FIFO flushed (flush beats push/pop same cycle), `pc_inc=0`. Next state: WAIT without ack → DRAIN; WAIT with ack → FETCH (data dropped); DRAIN without ack → DRAIN; otherwise FETCH.
- DRAIN: hold `imem_req=1`, `imem_addr=req_addr` until `imem_ack`; drop data, no push, no `pc_inc`; go FETCH.
- Handshake: once raised, `imem_req` and `imem_addr` stay stable until the ack cycle; a request is never withdrawn except by `reset`.
- Output: `instr_valid = count != 0`; pop when `instr_valid && instr_ready`; simultaneous push and pop legal at any count, including full.
- `pc_inc` and `pc_load` are never high together; `pc_in = 0` when `pc_load = 0`.
- Address arithmetic is modulo 2^ADDR_W: `req_addr` 0xFFFF increments to 0x0000, matching PC wrap.

## Timing
- Reset (sync): state FETCH, FIFO empty; `imem_req`, `pc_inc`, `pc_load`, `instr_valid` = 0; `imem_addr`, `pc_in`, `instr`, `instr_pc` = 0. Reset mid-request abandons it; the memory is reset with the system.
- `imem_req` rises the cycle after FETCH sees space, so the first request follows reset by 1 cycle.
- Ack in cycle k: `instr_valid` high in cycle k+1. PC updates at the ack edge.
- Zero-wait memory (ack every request cycle): sustained 1 word/cycle while decode drains.
- Jump in cycle j: PC holds `jump_target` from j+1, and `instr_valid=0` in j+1. The first target word is ack-able no earlier than j+2, or one cycle after the DRAIN ack.
- All outputs are from registers or state decode. `pc_inc`/`pc_load`/`pc_in` are combinational from state, `imem_ack` and `jump`. No input-to-output path other than these.

## Structure
- Package `fetch_pkg`: state enum {FETCH, WAIT, DRAIN}, default `ADDR_W`/`DATA_W`, FIFO entry struct {addr, data}.
- Sub-module `fetch_fifo`: synchronous DEPTH-entry FIFO with push, pop, flush, count, head outputs. Flush has priority.
- `fetch_unit` holds the FSM, `req_addr`, and PC control decode.

## Test plan
- Reset then zero-wait memory returning data = addr ^ 0xA5A5, decode always ready -> `instr_pc` 0,1,2,3… on consecutive cycles, `pc_inc` high each ack cycle.
- Decode stalled (`instr_ready=0`), DEPTH=2 -> exactly 2 pushes then `imem_req` low, PC = 2. Release ready -> fetching resumes at address 2.
- 3-cycle ack latency, `jump` to 0x0100 in the first wait cycle -> DRAIN; addr/req stable until ack; data discarded; next request addr 0x0100; no stale `instr_valid`.
- `jump` and `imem_ack` in the same cycle -> data dropped, `pc_load=1`, `pc_inc=0`, state FETCH, FIFO empty next cycle.
- `jump_target=0xFFFE`, zero-wait -> `instr_pc` 0xFFFE, 0xFFFF, 0x0000.
- `reset` asserted during WAIT with a full FIFO -> next cycle all outputs 0, `imem_req` low, then fetch restarts from the PC's reset value.
